hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: architectural register count; RW = $clog2(NUM_REGS).
REQ-002 Parameter DEPTH, default 3: number of tracked in-flight stages after decode; entry 0 = EX, DEPTH-1 = WB.
REQ-003 Parameter LOAD_AVAIL, default 1: first entry index whose load data is forwardable; 1 <= LOAD_AVAIL < DEPTH.
REQ-004 Parameter ZERO_REG, default 31: hardwired-zero register, never a hazard or forward source.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 dec_valid  in  1  decode stage holds a real instruction.
REQ-008 dec_rd, dec_src_a, dec_src_b  in  RW each  destination and source register numbers of the decode instruction.
REQ-009 dec_we, dec_load, dec_set_flags, dec_use_a, dec_use_b, dec_use_flags  in  1 each  decode-instruction attributes.
REQ-010 flush  in  1  taken branch; squash the decode instruction.
REQ-011 stall  out  1  hold PC and IF/RF register; insert bubble.
REQ-012 fwd_sel_a, fwd_sel_b  out  $clog2(DEPTH+1)  0 = register file, k = forward from entry k-1.
REQ-013 flag_sel  out  $clog2(DEPTH+1)  0 = flag register, k = flags from entry k-1.

Function
REQ-014 Scoreboard SHALL hold DEPTH entries {valid, rd, we, load, set_flags}.
REQ-015 Each posedge: entry j <= entry j-1 for j >= 1; the pipeline back end never stalls.
REQ-016 Entry 0 SHALL load the decode attributes with valid=1 iff dec_valid && !stall && !flush; otherwise entry 0 SHALL become a bubble (valid=0).
REQ-017 An entry SHALL match source s iff valid && we && rd == s && s != ZERO_REG.
REQ-018 fwd_sel_x SHALL be k+1 for the lowest-index (youngest) matching entry k, else 0; combinational, zero latency; 0 when dec_use_x=0.
REQ-019 stall SHALL assert iff dec_valid && !flush and a used source's youngest match is an entry k < LOAD_AVAIL with load=1.
REQ-020 flag_sel SHALL be k+1 for the lowest valid entry k with set_flags=1 when dec_use_flags=1, else 0.
REQ-021 A flag-setting load at k < LOAD_AVAIL read via dec_use_flags SHALL also assert stall.
REQ-022 flush and stall in the same cycle: flush wins; stall=0 and entry 0 becomes a bubble.
REQ-023 An older entry matching behind a younger non-load match SHALL NOT cause a stall.
REQ-024 dec_valid=0: stall=0, fwd_sel_a=fwd_sel_b=flag_sel=0.

Reset
REQ-025 reset low SHALL immediately clear every entry valid bit; all outputs SHALL read 0 while reset is low and on the first cycle after release.
REQ-026 Reset asserted mid-stall SHALL drop stall asynchronously; no pending hazard state survives.

Configuration
REQ-027 With HAZARD_PERF_EN defined: outputs stall_cnt [31:0] and flush_cnt [31:0], saturating at 32'hFFFF_FFFF, incremented on each posedge with stall=1 or flush=1 respectively, and cleared by reset.
REQ-028 Without HAZARD_PERF_EN: those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package hazard_pkg SHALL hold the sb_entry_t struct typedef and FWD_RF = 0.
REQ-030 A single sub-module, sb_match, SHALL implement the youngest-match priority search, instantiated once for each of src A, src B, and flags.

Verification
REQ-031 ADD X1 issued, then dependent ADD reads X1 in the next cycle -> fwd_sel_a=1, stall=0.
REQ-032 LDUR X2 issued, then dependent ADD reads X2 -> stall=1 for exactly one cycle, then fwd_sel_b=2 with a bubble in entry 0.
REQ-033 X31 written then read -> fwd_sel=0, stall=0.
REQ-034 X3 written at entries 0 and 2 -> fwd_sel_a=1, the youngest entry.
REQ-035 Load-use hazard with flush=1 in the same cycle -> stall=0, next-cycle entry 0 is invalid; SUBS then B.LT -> flag_sel=1.
REQ-036 reset pulsed low during a stall -> stall drops within the same cycle; perf counters (HAZARD_PERF_EN) read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard scoreboard
//
// Purpose: scoreboard entry record and the "read from register file" select
// code shared by hazard_scoreboard and sb_match.
// Ports: none (package).
// Config macro used elsewhere in this slice: HAZARD_PERF_EN.

package hazard_pkg;

  // Entry rd field is sized for up to 256 architectural registers; narrower
  // register numbers are zero-extended into it.
  localparam int SB_RD_W = 8;

  // Select code meaning "no forward, use the register file / flag register".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               we;
    logic               load;
    logic               set_flags;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-match priority search over scoreboard entries
//
// Purpose: given a per-entry hit vector, select the lowest-index (youngest)
// hit and report whether that entry is a load whose data is not yet
// forwardable.
// Ports:
//   hit      in  DEPTH            per-entry match qualifier
//   load     in  DEPTH            per-entry load attribute
//   sel      out clog2(DEPTH+1)   0 = no match, k = entry k-1 matched
//   load_use out 1                youngest match is a load below LOAD_AVAIL

module sb_match
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 1
) (
  input  logic [DEPTH-1:0]             hit,
  input  logic [DEPTH-1:0]             load,
  output logic [$clog2(DEPTH+1)-1:0]   sel,
  output logic                         load_use
);

  localparam int SW = $clog2(DEPTH + 1);

  // Scan oldest to youngest so the last (lowest-index) hit wins.
  always_comb begin
    sel      = SW'(FWD_RF);
    load_use = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel      = SW'(k + 1);
        load_use = load[k] && (k < LOAD_AVAIL);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-order pipeline hazard scoreboard (stall + forward select)
//
// Purpose: tracks DEPTH in-flight instructions behind decode, drives
// load-use stall and register/flag forwarding selects for the decode stage.
// Ports:
//   clk, reset (async active-low)
//   dec_valid, dec_rd, dec_src_a, dec_src_b        decode instruction
//   dec_we, dec_load, dec_set_flags                decode attributes
//   dec_use_a, dec_use_b, dec_use_flags            which sources are read
//   flush                                          squash decode instruction
//   stall                                          hold front end, bubble
//   fwd_sel_a, fwd_sel_b, flag_sel                 0 = RF, k = entry k-1
//   stall_cnt, flush_cnt (only with HAZARD_PERF_EN) saturating event counters

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 1,
  parameter int ZERO_REG   = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dec_valid,
  input  logic [$clog2(NUM_REGS)-1:0]   dec_rd,
  input  logic [$clog2(NUM_REGS)-1:0]   dec_src_a,
  input  logic [$clog2(NUM_REGS)-1:0]   dec_src_b,
  input  logic                          dec_we,
  input  logic                          dec_load,
  input  logic                          dec_set_flags,
  input  logic                          dec_use_a,
  input  logic                          dec_use_b,
  input  logic                          dec_use_flags,
  input  logic                          flush,
  output logic                          stall,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_a,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_b,
  output logic [$clog2(DEPTH+1)-1:0]    flag_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   flush_cnt
`endif
);

  localparam int RW = $clog2(NUM_REGS);

  sb_entry_t        sb [DEPTH];
  sb_entry_t        dec_entry;
  logic [DEPTH-1:0] hit_a, hit_b, hit_f, ld_vec;
  logic             lu_a, lu_b, lu_f;
  logic             zero_a, zero_b;

  assign zero_a = (dec_src_a == RW'(ZERO_REG));
  assign zero_b = (dec_src_b == RW'(ZERO_REG));

  // Hits are qualified by dec_valid and the use bits, so an idle decode slot
  // or an unused operand always yields select 0 and never stalls.
  always_comb begin
    hit_a  = '0;
    hit_b  = '0;
    hit_f  = '0;
    ld_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ld_vec[k] = sb[k].load;
      hit_a[k]  = dec_valid && dec_use_a && !zero_a && sb[k].valid && sb[k].we &&
                  (sb[k].rd == SB_RD_W'(dec_src_a));
      hit_b[k]  = dec_valid && dec_use_b && !zero_b && sb[k].valid && sb[k].we &&
                  (sb[k].rd == SB_RD_W'(dec_src_b));
      hit_f[k]  = dec_valid && dec_use_flags && sb[k].valid && sb[k].set_flags;
    end
  end

  sb_match #(.DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL)) u_match_a (
    .hit(hit_a), .load(ld_vec), .sel(fwd_sel_a), .load_use(lu_a)
  );

  sb_match #(.DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL)) u_match_b (
    .hit(hit_b), .load(ld_vec), .sel(fwd_sel_b), .load_use(lu_b)
  );

  sb_match #(.DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL)) u_match_f (
    .hit(hit_f), .load(ld_vec), .sel(flag_sel), .load_use(lu_f)
  );

  // Flush overrides stall: the dependent instruction is being squashed, so
  // there is nothing to hold.
  assign stall = dec_valid && !flush && (lu_a || lu_b || lu_f);

  always_comb begin
    dec_entry           = '0;
    dec_entry.valid     = dec_valid && !stall && !flush;
    dec_entry.rd        = SB_RD_W'(dec_rd);
    dec_entry.we        = dec_we;
    dec_entry.load      = dec_load;
    dec_entry.set_flags = dec_set_flags;
  end

  // Back end never stalls: entries shift every cycle, decode or a bubble
  // enters at entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        sb[j] <= '0;
      end
    end else begin
      sb[0] <= dec_entry;
      for (int j = 1; j < DEPTH; j++) begin
        sb[j] <= sb[j-1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard

module tb_hazard_scoreboard;

  localparam int DEPTH      = 3;
  localparam int LOAD_AVAIL = 1;
  localparam int ZERO_REG   = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rd, dec_src_a, dec_src_b;
  logic       dec_we, dec_load, dec_set_flags;
  logic       dec_use_a, dec_use_b, dec_use_flags;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_sel_a, fwd_sel_b, flag_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  longint      m_stall_cnt, m_flush_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rd(dec_rd),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_we(dec_we), .dec_load(dec_load), .dec_set_flags(dec_set_flags),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_use_flags(dec_use_flags),
    .flush(flush), .stall(stall),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .flag_sel(flag_sel)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: history of what was issued in each of the last DEPTH
  // cycles, index 0 = most recent issue slot.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
    bit sf;
  } rec_t;

  rec_t hist [$];
  int   errors = 0;
  int   checks = 0;
  int   exp_stall, exp_a, exp_b, exp_f;
  int   obs_stall, obs_a, obs_b, obs_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    rec_t b;
    b.v = 0; b.rd = 0; b.we = 0; b.ld = 0; b.sf = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(b);
`ifdef HAZARD_PERF_EN
    m_stall_cnt = 0;
    m_flush_cnt = 0;
`endif
  endtask

  function automatic int youngest(int src, bit used);
    if (!used || src == ZERO_REG) return 0;
    for (int k = 0; k < DEPTH; k++)
      if (hist[k].v && hist[k].we && hist[k].rd == src) return k + 1;
    return 0;
  endfunction

  function automatic int youngest_flags(bit used);
    if (!used) return 0;
    for (int k = 0; k < DEPTH; k++)
      if (hist[k].v && hist[k].sf) return k + 1;
    return 0;
  endfunction

  function automatic bit early_load(int sel);
    if (sel == 0) return 0;
    return (sel - 1 < LOAD_AVAIL) && hist[sel-1].ld;
  endfunction

  task automatic predict();
    if (!dec_valid) begin
      exp_a = 0; exp_b = 0; exp_f = 0; exp_stall = 0;
    end else begin
      exp_a = youngest(int'(dec_src_a), dec_use_a);
      exp_b = youngest(int'(dec_src_b), dec_use_b);
      exp_f = youngest_flags(dec_use_flags);
      exp_stall = (!flush && (early_load(exp_a) || early_load(exp_b) || early_load(exp_f))) ? 1 : 0;
    end
  endtask

  task automatic issue(input bit dv, input int rd, input int a, input int b,
                       input bit we, input bit ld, input bit sf,
                       input bit ua, input bit ub, input bit uf, input bit fl);
    dec_valid = dv; dec_rd = 5'(rd); dec_src_a = 5'(a); dec_src_b = 5'(b);
    dec_we = we; dec_load = ld; dec_set_flags = sf;
    dec_use_a = ua; dec_use_b = ub; dec_use_flags = uf; flush = fl;
  endtask

  task automatic check_outputs(input string tag);
    predict();
    obs_stall = int'(stall); obs_a = int'(fwd_sel_a);
    obs_b = int'(fwd_sel_b); obs_f = int'(flag_sel);
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check({tag, "_fwd_a"}, 32'(fwd_sel_a), 32'(exp_a));
    check({tag, "_fwd_b"}, 32'(fwd_sel_b), 32'(exp_b));
    check({tag, "_flag"}, 32'(flag_sel), 32'(exp_f));
`ifdef HAZARD_PERF_EN
    check({tag, "_stall_cnt"}, stall_cnt, 32'(m_stall_cnt));
    check({tag, "_flush_cnt"}, flush_cnt, 32'(m_flush_cnt));
`endif
  endtask

  // One clock: check combinational outputs at the negedge, then advance the
  // model on the posedge. Called from posedge+1.
  task automatic cycle(input string tag);
    rec_t r;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    r.v  = dec_valid && (exp_stall == 0) && !flush;
    r.rd = int'(dec_rd); r.we = dec_we; r.ld = dec_load; r.sf = dec_set_flags;
    hist.push_front(r);
    hist.delete(DEPTH);
`ifdef HAZARD_PERF_EN
    if (exp_stall != 0 && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    if (flush && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
`endif
    #1;
  endtask

  initial begin
    clear_model();
    reset = 1'b0;
    // Decode presents a would-be dependent instruction while in reset.
    issue(1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 0);
    #12;
    check_outputs("rst_low");
    @(posedge clk); #1;
    check_outputs("rst_low_edge");
    reset = 1'b1;
    issue(1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0);
    cycle("rst_first");
    check("rst_first_const_stall", 32'(obs_stall), 32'd0);

    // ADD X1 then dependent ADD reads X1.
    issue(1, 1, 5, 6, 1, 0, 0, 1, 1, 0, 0);
    cycle("add_x1");
    issue(1, 9, 1, 7, 1, 0, 0, 1, 1, 0, 0);
    cycle("add_dep");
    check("add_dep_const_fwd_a", 32'(obs_a), 32'd1);
    check("add_dep_const_stall", 32'(obs_stall), 32'd0);

    // LDUR X2 then dependent ADD on src B: one stall cycle, then forward from entry 1.
    issue(1, 2, 5, 6, 1, 1, 0, 1, 0, 0, 0);
    cycle("ldur_x2");
    issue(1, 10, 4, 2, 1, 0, 0, 1, 1, 0, 0);
    cycle("ldu_stall");
    check("ldu_stall_const", 32'(obs_stall), 32'd1);
    cycle("ldu_resume");
    check("ldu_resume_const_stall", 32'(obs_stall), 32'd0);
    check("ldu_resume_const_fwd_b", 32'(obs_b), 32'd2);

    // Write X31 then read it: never forwarded.
    issue(1, 31, 1, 2, 1, 0, 0, 1, 1, 0, 0);
    cycle("x31_wr");
    issue(1, 11, 31, 31, 1, 0, 0, 1, 1, 0, 0);
    cycle("x31_rd");
    check("x31_rd_const_fwd_a", 32'(obs_a), 32'd0);

    // X3 at entries 0 and 2: youngest wins.
    issue(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("x3_a");
    issue(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("x5");
    issue(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("x3_b");
    issue(1, 12, 3, 0, 1, 0, 0, 1, 0, 0, 0); cycle("x3_rd");
    check("x3_rd_const_fwd_a", 32'(obs_a), 32'd1);

    // Load-use with flush in the same cycle: no stall, bubble enters.
    issue(1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("ld_x4");
    issue(1, 4, 4, 0, 1, 0, 0, 1, 0, 0, 1); cycle("ld_x4_flush");
    check("ld_x4_flush_const_stall", 32'(obs_stall), 32'd0);
    issue(1, 13, 4, 0, 1, 0, 0, 1, 0, 0, 0); cycle("after_flush");
    check("after_flush_const_fwd_a", 32'(obs_a), 32'd2);

    // SUBS then B.LT.
    issue(1, 7, 1, 2, 1, 0, 1, 1, 1, 0, 0); cycle("subs");
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle("blt");
    check("blt_const_flag", 32'(obs_f), 32'd1);

    // Older load behind a younger non-load match: no stall.
    issue(1, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("ld_x6");
    issue(1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0); cycle("add_x6");
    issue(1, 14, 6, 6, 1, 0, 0, 1, 1, 0, 0); cycle("rd_x6");
    check("rd_x6_const_stall", 32'(obs_stall), 32'd0);

    // Flag-setting load read through flags: stall.
    issue(1, 8, 0, 0, 1, 1, 1, 0, 0, 0, 0); cycle("ld_flags");
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle("flag_use");
    check("flag_use_const_stall", 32'(obs_stall), 32'd1);
    cycle("flag_resume");

    // dec_valid low with matching sources: all outputs zero.
    issue(1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0); cycle("ld_x2b");
    issue(0, 0, 2, 2, 0, 0, 0, 1, 1, 1, 0); cycle("dv_low");
    check("dv_low_const_stall", 32'(obs_stall), 32'd0);

    // Randomized traffic over a small register pool.
    for (int i = 0; i < 300; i++) begin
      int ra, rb, rdv;
      rdv = ($urandom_range(0, 7) == 0) ? ZERO_REG : int'($urandom_range(0, 5));
      ra  = ($urandom_range(0, 7) == 0) ? ZERO_REG : int'($urandom_range(0, 5));
      rb  = int'($urandom_range(0, 5));
      issue($urandom_range(0, 9) != 0, rdv, ra, rb,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    // Reset pulsed mid-stall: stall drops without a clock edge.
    issue(1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0); cycle("mid_ld");
    issue(1, 15, 2, 2, 1, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    check_outputs("mid_pre");
    check("mid_pre_const_stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    check_outputs("mid_rst");
    check("mid_rst_const_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cycle("mid_release");
    check("mid_release_const_stall", 32'(obs_stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
